// File: rtl/pomodoro_sequencer.sv
// rtl/pomodoro_sequencer.sv - Pomodoro session controller: phase sequencing and mm:ss countdown
module pomodoro_sequencer #(
  parameter int WORK_MIN    = 25,
  parameter int SHORT_MIN   = 5,
  parameter int LONG_MIN    = 15,
  parameter int CYCLES_LONG = 4,
  parameter int AUTO_START  = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       tick,
  input  logic       start_pause,
  input  logic       skip,
  output logic [1:0] phase,
  output logic [6:0] minutes,
  output logic [5:0] seconds,
  output logic       running,
  output logic       phase_done,
  output logic [3:0] pomo_count,
  output logic       tick_clear
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_WORK  = 2'd1,
    S_SHORT = 2'd2,
    S_LONG  = 2'd3
  } state_t;

  localparam logic [6:0] C_WORK   = 7'(WORK_MIN);
  localparam logic [6:0] C_SHORT  = 7'(SHORT_MIN);
  localparam logic [6:0] C_LONG   = 7'(LONG_MIN);
  localparam logic [3:0] C_CYCLES = 4'(CYCLES_LONG);
  localparam logic       C_AUTO   = (AUTO_START != 0);

  state_t     r_state, w_state;
  logic [6:0] r_min, w_min;
  logic [5:0] r_sec, w_sec;
  logic       r_run, w_run;
  logic       r_done, w_done;
  logic [3:0] r_pomo, w_pomo;
  logic       r_tc, w_tc;
  logic       r_sp_q, r_sk_q;

  logic       w_sp_ev, w_sk_ev, w_expire;
  logic [3:0] w_pomo_inc;

  assign w_sp_ev    = start_pause & ~r_sp_q;
  assign w_sk_ev    = skip & ~r_sk_q;
  assign w_pomo_inc = r_pomo + 4'd1;
  // Expiry fires on the tick that would show 00:00, so 00:00 is never displayed.
  assign w_expire   = r_run & tick & ~w_sp_ev & (r_min == 7'd0) & (r_sec == 6'd1);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= S_IDLE;
      r_min   <= C_WORK;
      r_sec   <= 6'd0;
      r_run   <= 1'b0;
      r_done  <= 1'b0;
      r_pomo  <= 4'd0;
      r_tc    <= 1'b0;
      r_sp_q  <= 1'b0;
      r_sk_q  <= 1'b0;
    end else begin
      r_state <= w_state;
      r_min   <= w_min;
      r_sec   <= w_sec;
      r_run   <= w_run;
      r_done  <= w_done;
      r_pomo  <= w_pomo;
      r_tc    <= w_tc;
      r_sp_q  <= start_pause;
      r_sk_q  <= skip;
    end
  end

  always_comb begin
    w_state = r_state;
    w_min   = r_min;
    w_sec   = r_sec;
    w_run   = r_run;
    w_done  = 1'b0;
    w_pomo  = r_pomo;
    w_tc    = 1'b0;
    if (r_state == S_IDLE) begin
      if (w_sp_ev) begin
        w_state = S_WORK;
        w_min   = C_WORK;
        w_sec   = 6'd0;
        w_run   = 1'b1;
        w_tc    = 1'b1;
      end
    end else if (w_sk_ev || w_expire) begin
      w_done = 1'b1;
      w_tc   = 1'b1;
      w_sec  = 6'd0;
      w_run  = C_AUTO;
      if (r_state == S_WORK) begin
        if (w_pomo_inc == C_CYCLES) begin
          w_state = S_LONG;
          w_min   = C_LONG;
          w_pomo  = 4'd0;
        end else begin
          w_state = S_SHORT;
          w_min   = C_SHORT;
          w_pomo  = w_pomo_inc;
        end
      end else begin
        w_state = S_WORK;
        w_min   = C_WORK;
      end
    end else if (w_sp_ev) begin
      w_run = ~r_run;
      w_tc  = ~r_run;
    end else if (tick && r_run) begin
      if (r_sec != 6'd0) begin
        w_sec = r_sec - 6'd1;
      end else begin
        w_min = r_min - 7'd1;
        w_sec = 6'd59;
      end
    end
  end

  assign phase      = r_state;
  assign minutes    = r_min;
  assign seconds    = r_sec;
  assign running    = r_run;
  assign phase_done = r_done;
  assign pomo_count = r_pomo;
  assign tick_clear = r_tc;

endmodule

// File: tb/tb_pomodoro_sequencer.sv
// tb/tb_pomodoro_sequencer.sv - randomized and directed bench against a seconds-remaining model
module tb_pomodoro_sequencer;
  localparam int WORK_MIN = 2, SHORT_MIN = 1, LONG_MIN = 3, CYCLES_LONG = 2;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic tick = 1'b0, start_pause = 1'b0, skip = 1'b0;

  logic [1:0] ph0, ph1;
  logic [6:0] mn0, mn1;
  logic [5:0] sc0, sc1;
  logic       rn0, rn1, dn0, dn1, tc0, tc1;
  logic [3:0] pc0, pc1;
  logic [21:0] d0_vec, d1_vec;

  int errors = 0;
  int checks = 0;

  // Model: remaining time kept as a plain count of seconds.
  int m_phase, m_rem, m_pomo;
  bit m_run, m_done, m_tc, m_psp, m_psk;

  always #5 clk = ~clk;

  pomodoro_sequencer #(.WORK_MIN(WORK_MIN), .SHORT_MIN(SHORT_MIN), .LONG_MIN(LONG_MIN),
                       .CYCLES_LONG(CYCLES_LONG), .AUTO_START(1)) dut0 (
    .clk(clk), .rst(rst), .tick(tick), .start_pause(start_pause), .skip(skip),
    .phase(ph0), .minutes(mn0), .seconds(sc0), .running(rn0), .phase_done(dn0),
    .pomo_count(pc0), .tick_clear(tc0));

  pomodoro_sequencer #(.WORK_MIN(WORK_MIN), .SHORT_MIN(SHORT_MIN), .LONG_MIN(LONG_MIN),
                       .CYCLES_LONG(CYCLES_LONG), .AUTO_START(0)) dut1 (
    .clk(clk), .rst(rst), .tick(tick), .start_pause(start_pause), .skip(skip),
    .phase(ph1), .minutes(mn1), .seconds(sc1), .running(rn1), .phase_done(dn1),
    .pomo_count(pc1), .tick_clear(tc1));

  assign d0_vec = {ph0, mn0, sc0, rn0, dn0, pc0, tc0};
  assign d1_vec = {ph1, mn1, sc1, rn1, dn1, pc1, tc1};

  function automatic logic [21:0] pack(int ph, int mn, int sc, int rn, int dn, int pc, int tc);
    return {2'(ph), 7'(mn), 6'(sc), 1'(rn), 1'(dn), 4'(pc), 1'(tc)};
  endfunction

  function automatic logic [21:0] exp_vec();
    return pack(m_phase, m_rem / 60, m_rem % 60, int'(m_run), int'(m_done), m_pomo, int'(m_tc));
  endfunction

  task automatic model_reset();
    m_phase = 0; m_rem = WORK_MIN * 60; m_pomo = 0;
    m_run = 0; m_done = 0; m_tc = 0; m_psp = 0; m_psk = 0;
  endtask

  task automatic model_end_phase();
    m_done = 1; m_tc = 1; m_run = 1;
    if (m_phase == 1) begin
      m_pomo = m_pomo + 1;
      if (m_pomo == CYCLES_LONG) begin
        m_phase = 3; m_pomo = 0; m_rem = LONG_MIN * 60;
      end else begin
        m_phase = 2; m_rem = SHORT_MIN * 60;
      end
    end else begin
      m_phase = 1; m_rem = WORK_MIN * 60;
    end
  endtask

  task automatic model_step(input bit t, input bit sp, input bit sk);
    bit sp_ev, sk_ev;
    sp_ev = sp && !m_psp;
    sk_ev = sk && !m_psk;
    m_psp = sp; m_psk = sk;
    m_done = 0; m_tc = 0;
    if (m_phase == 0) begin
      if (sp_ev) begin
        m_phase = 1; m_rem = WORK_MIN * 60; m_run = 1; m_tc = 1;
      end
    end else if (sk_ev) begin
      model_end_phase();
    end else if (sp_ev) begin
      m_tc = !m_run;
      m_run = !m_run;
    end else if (t && m_run) begin
      if (m_rem == 1) model_end_phase();
      else m_rem = m_rem - 1;
    end
  endtask

  task automatic step(input bit t, input bit sp, input bit sk);
    tick = t; start_pause = sp; skip = sk;
    @(posedge clk);
    model_step(t, sp, sk);
    #1;
  endtask

  task automatic do_reset();
    tick = 0; start_pause = 0; skip = 0;
    rst = 1'b0;
    #3;
    model_reset();
    @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if (d0_vec !== pack(0, WORK_MIN, 0, 0, 0, 0, 0)) begin
      errors++; $display("FAIL reset_auto got=%h want=%h", d0_vec, pack(0, WORK_MIN, 0, 0, 0, 0, 0));
    end
    checks++;
    if (d1_vec !== pack(0, WORK_MIN, 0, 0, 0, 0, 0)) begin
      errors++; $display("FAIL reset_manual got=%h want=%h", d1_vec, pack(0, WORK_MIN, 0, 0, 0, 0, 0));
    end
  endtask

  task automatic test_start_countdown();
    step(0, 1, 0);
    checks++;
    if (d0_vec !== pack(1, 2, 0, 1, 0, 0, 1)) begin
      errors++; $display("FAIL start got=%h want=%h", d0_vec, pack(1, 2, 0, 1, 0, 0, 1));
    end
    step(0, 0, 0);
    checks++;
    if (tc0 !== 1'b0) begin
      errors++; $display("FAIL tick_clear_width got=%b want=0", tc0);
    end
    step(1, 0, 0);
    checks++;
    if ({mn0, sc0} !== {7'd1, 6'd59}) begin
      errors++; $display("FAIL first_tick got=%0d:%0d want=1:59", mn0, sc0);
    end
    for (int i = 0; i < 60; i++) begin
      step(1, 0, 0);
      checks++;
      if (d0_vec !== exp_vec()) begin
        errors++; $display("FAIL countdown got=%h want=%h", d0_vec, exp_vec());
      end
    end
    checks++;
    if ({mn0, sc0} !== {7'd0, 6'd59}) begin
      errors++; $display("FAIL at_0059 got=%0d:%0d want=0:59", mn0, sc0);
    end
  endtask

  task automatic run_ticks(input int n, input string name);
    for (int i = 0; i < n; i++) begin
      step(1, 0, 0);
      checks++;
      if (d0_vec !== exp_vec()) begin
        errors++; $display("FAIL %s got=%h want=%h", name, d0_vec, exp_vec());
      end
    end
  endtask

  task automatic test_phase_sequence();
    run_ticks(59, "work_expiry");
    checks++;
    if (d0_vec !== pack(2, 1, 0, 1, 1, 1, 1)) begin
      errors++; $display("FAIL work_to_short got=%h want=%h", d0_vec, pack(2, 1, 0, 1, 1, 1, 1));
    end
    step(0, 0, 0);
    checks++;
    if ({dn0, tc0} !== 2'b00) begin
      errors++; $display("FAIL done_width got=%b want=00", {dn0, tc0});
    end
    run_ticks(60, "short_expiry");
    checks++;
    if (d0_vec !== pack(1, 2, 0, 1, 1, 1, 1)) begin
      errors++; $display("FAIL short_to_work got=%h want=%h", d0_vec, pack(1, 2, 0, 1, 1, 1, 1));
    end
    run_ticks(120, "work2_expiry");
    checks++;
    if (d0_vec !== pack(3, 3, 0, 1, 1, 0, 1)) begin
      errors++; $display("FAIL work_to_long got=%h want=%h", d0_vec, pack(3, 3, 0, 1, 1, 0, 1));
    end
    run_ticks(180, "long_expiry");
    checks++;
    if (d0_vec !== pack(1, 2, 0, 1, 1, 0, 1)) begin
      errors++; $display("FAIL long_to_work got=%h want=%h", d0_vec, pack(1, 2, 0, 1, 1, 0, 1));
    end
  endtask

  task automatic test_pause();
    run_ticks(30, "to_0130");
    step(0, 1, 0);
    checks++;
    if (d0_vec !== pack(1, 1, 30, 0, 0, 0, 0)) begin
      errors++; $display("FAIL pause got=%h want=%h", d0_vec, pack(1, 1, 30, 0, 0, 0, 0));
    end
    run_ticks(5, "paused_ticks");
    checks++;
    if ({mn0, sc0, rn0} !== {7'd1, 6'd30, 1'b0}) begin
      errors++; $display("FAIL frozen got=%0d:%0d run=%b want=1:30 run=0", mn0, sc0, rn0);
    end
    step(0, 1, 0);
    checks++;
    if ({rn0, tc0} !== 2'b11) begin
      errors++; $display("FAIL resume got=%b want=11", {rn0, tc0});
    end
    step(1, 0, 0);
    checks++;
    if ({mn0, sc0} !== {7'd1, 6'd29}) begin
      errors++; $display("FAIL resume_tick got=%0d:%0d want=1:29", mn0, sc0);
    end
  endtask

  task automatic test_skip();
    int done_cnt;
    step(0, 0, 1);
    checks++;
    if (d0_vec !== pack(2, 1, 0, 1, 1, 1, 1)) begin
      errors++; $display("FAIL skip_work got=%h want=%h", d0_vec, pack(2, 1, 0, 1, 1, 1, 1));
    end
    do_reset();
    step(0, 0, 1);
    step(1, 0, 1);
    checks++;
    if (d0_vec !== pack(0, 2, 0, 0, 0, 0, 0)) begin
      errors++; $display("FAIL skip_idle got=%h want=%h", d0_vec, pack(0, 2, 0, 0, 0, 0, 0));
    end
    step(0, 1, 0);
    step(0, 0, 0);
    done_cnt = 0;
    for (int i = 0; i < 10; i++) begin
      step(0, 0, 1);
      if (dn0 === 1'b1) done_cnt++;
      checks++;
      if (d0_vec !== exp_vec()) begin
        errors++; $display("FAIL skip_held got=%h want=%h", d0_vec, exp_vec());
      end
    end
    checks++;
    if (done_cnt != 1 || ph0 !== 2'd2) begin
      errors++; $display("FAIL skip_once got=%0d pulses phase=%0d want=1 pulse phase=2", done_cnt, ph0);
    end
    step(0, 0, 0);
  endtask

  task automatic test_same_cycle();
    do_reset();
    step(0, 1, 0);
    step(0, 0, 0);
    run_ticks(50, "to_0110");
    step(1, 0, 1);
    checks++;
    if (d0_vec !== pack(2, 1, 0, 1, 1, 1, 1)) begin
      errors++; $display("FAIL tick_skip got=%h want=%h", d0_vec, pack(2, 1, 0, 1, 1, 1, 1));
    end
    step(0, 0, 0);
    run_ticks(20, "to_0040");
    step(1, 1, 0);
    checks++;
    if ({mn0, sc0, rn0} !== {7'd0, 6'd40, 1'b0}) begin
      errors++; $display("FAIL tick_pause got=%0d:%0d run=%b want=0:40 run=0", mn0, sc0, rn0);
    end
    step(0, 0, 0);
  endtask

  task automatic test_random();
    bit sp_lvl, sk_lvl, t;
    do_reset();
    sp_lvl = 0; sk_lvl = 0;
    for (int i = 0; i < 4000; i++) begin
      t = bit'($urandom_range(0, 1));
      if ($urandom_range(0, 39) == 0) sp_lvl = !sp_lvl;
      if ($urandom_range(0, 79) == 0) sk_lvl = !sk_lvl;
      step(t, sp_lvl, sk_lvl);
      checks++;
      if (d0_vec !== exp_vec()) begin
        errors++; $display("FAIL random cyc=%0d got=%h want=%h", i, d0_vec, exp_vec());
      end
    end
  endtask

  task automatic test_manual_start();
    do_reset();
    step(0, 1, 0);
    step(0, 0, 0);
    for (int i = 0; i < 120; i++) step(1, 0, 0);
    checks++;
    if (d1_vec !== pack(2, 1, 0, 0, 1, 1, 1)) begin
      errors++; $display("FAIL manual_expiry got=%h want=%h", d1_vec, pack(2, 1, 0, 0, 1, 1, 1));
    end
    for (int i = 0; i < 5; i++) step(1, 0, 0);
    checks++;
    if (d1_vec !== pack(2, 1, 0, 0, 0, 1, 0)) begin
      errors++; $display("FAIL manual_hold got=%h want=%h", d1_vec, pack(2, 1, 0, 0, 0, 1, 0));
    end
    step(0, 1, 0);
    checks++;
    if ({rn1, tc1} !== 2'b11) begin
      errors++; $display("FAIL manual_resume got=%b want=11", {rn1, tc1});
    end
    step(0, 0, 0);
    for (int i = 0; i < 60; i++) step(1, 0, 0);
    step(0, 1, 0);
    step(0, 0, 0);
    for (int i = 0; i < 120; i++) step(1, 0, 0);
    step(0, 1, 0);
    step(1, 0, 0);
    step(1, 0, 0);
    checks++;
    if (d1_vec !== pack(3, 2, 58, 1, 0, 0, 0)) begin
      errors++; $display("FAIL manual_long got=%h want=%h", d1_vec, pack(3, 2, 58, 1, 0, 0, 0));
    end
  endtask

  task automatic test_async_reset();
    #2;
    rst = 1'b0;
    #1;
    checks++;
    if (d1_vec !== pack(0, 2, 0, 0, 0, 0, 0)) begin
      errors++; $display("FAIL async_reset got=%h want=%h", d1_vec, pack(0, 2, 0, 0, 0, 0, 0));
    end
    checks++;
    if (d0_vec !== pack(0, 2, 0, 0, 0, 0, 0)) begin
      errors++; $display("FAIL async_reset_auto got=%h want=%h", d0_vec, pack(0, 2, 0, 0, 0, 0, 0));
    end
    @(negedge clk);
    rst = 1'b1;
  endtask

  initial begin
    model_reset();
    test_reset();
    test_start_countdown();
    test_phase_sequence();
    test_pause();
    test_skip();
    test_same_cycle();
    test_random();
    test_manual_start();
    test_async_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
